dot_product_accumulator: RTL
============================

Name: dot_product_accumulator

Overview:
Downstream consumer of the 16x16 pipelined multiplier in the matrix-multiply datapath. Each cycle its done strobe is high, the block takes the 32-bit product and sums a programmed number of products into one dot-product element (one output matrix cell). It presents the finished sum to the result writer over a valid/ready handshake and holds the sum until the writer accepts it.

Parameters:
LEN_W, 4, width of the vector-length input; maximum dot-product length is 2^LEN_W-1.
PROD_W, 32, product width; matches the multiplier result.
ACC_W, PROD_W+LEN_W, accumulator and output width; sized so overflow is impossible.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; name follows codebase convention, polarity is low-true
start  input  1  1-cycle request to begin a new dot product
len  input  LEN_W  number of products to sum, sampled on accepted start
prod  input  PROD_W  product from the multiplier result port
prod_done  input  1  product-valid qualifier from the multiplier done; 1 product per high cycle
acc_out  output  ACC_W  finished dot-product sum
acc_valid  output  1  acc_out holds a finished sum
acc_ready  input  1  downstream accepts acc_out when high with acc_valid
busy  output  1  block is in ACCUM or HOLD
err  output  1  sticky: a product arrived when none was expected

Behaviour:
- Reset (reset=0, async): state=IDLE; acc, cnt, acc_out=0; acc_valid=0; busy=0; err=0. Reset mid-operation discards the partial sum immediately; no output is produced for that sum.
- All outputs are registered.
- IDLE state:
  - start=1, len!=0: acc<=0, cnt<=len, go to ACCUM.
  - start=1, len=0 (empty vector): acc_out<=0, acc_valid<=1, go to HOLD.
  - prod_done=1: product dropped, err<=1.
- ACCUM state (busy=1):
  - Each prod_done=1 cycle: acc<=acc+zero-extended prod, cnt<=cnt-1.
  - prod_done=1 with cnt==1: acc_out<=acc+prod, acc_valid<=1, go to HOLD. acc_valid is visible the cycle after the edge that samples the final product.
  - Gaps (prod_done=0) leave acc and cnt unchanged.
  - start is ignored; it does not set err.
- HOLD state (acc_valid=1, busy=1):
  - acc_out stays stable until the handshake.
  - acc_valid && acc_ready: acc_valid<=0, go to IDLE.
  - Same-cycle acc_ready=1 and start=1: accept start in that edge. len!=0 goes straight to ACCUM with acc<=0; len=0 reloads acc_out<=0 and stays in HOLD with acc_valid=1. No idle bubble.
  - start without acc_ready: ignored.
  - prod_done=1: product dropped, err<=1; acc_out is not modified.
- err is cleared only by reset.
- Arithmetic: unsigned; sum ≤ (2^LEN_W-1)*(2^PROD_W-1) < 2^ACC_W, so no wrap check is required.
- Simultaneous prod_done (final product) and start in ACCUM: the final product is accumulated and start is ignored.

Test Plan:
1. len=3, prod=10,20,30 with prod_done high 3 consecutive cycles, acc_ready=1 → acc_out=60 (0x3C), acc_valid high exactly 1 cycle starting the cycle after prod=30 is sampled; busy low the following cycle; err=0.
2. len=15, prod=0xFFFFFFFF on 15 strobes with random 0-3 cycle gaps → acc_out=0xE_FFFF_FFF1 (36-bit), no wrap.
3. Finish len=2 (prod 5,7) with acc_ready=0 for 6 cycles, plus one prod_done pulse (prod=99) during HOLD → acc_out stays 12, acc_valid stays 1, err=1. Raise acc_ready → acc_valid drops next cycle; err stays 1.
4. start with len=0 in IDLE → next cycle acc_valid=1, acc_out=0, busy=1; accepted on acc_ready.
5. Back-to-back: in HOLD with sum 12, drive acc_ready=1 and start=1 with len=2 in the same cycle; then prod 100,200 → first sum accepted, no IDLE cycle (busy stays 1), second acc_out=300.
6. Drive reset=0 asynchronously between clock edges mid-ACCUM after 2 of 4 products → outputs go to 0 before the next edge. Release reset, start len=1, prod=42 → acc_out=42, err=0.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of multiplier products into one dot-product element
// and holds the result on a valid/ready handshake until the writer takes it.
module dot_product_accumulator #(
    parameter int LEN_W  = 4,
    parameter int PROD_W = 32,
    parameter int ACC_W  = PROD_W + LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [ACC_W-1:0]   acc_out_n;
    logic               acc_valid_n;
    logic               err_n;
    logic [ACC_W-1:0]   sum;

    assign sum = acc + ACC_W'(prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            acc_out   <= acc_out_n;
            acc_valid <= acc_valid_n;
            busy      <= (state_n != IDLE);
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        acc_out_n   = acc_out;
        acc_valid_n = acc_valid;
        err_n       = err;

        unique case (state)
            IDLE: begin
                if (prod_done) begin
                    err_n = 1'b1;
                end
                if (start) begin
                    if (len != '0) begin
                        acc_n   = '0;
                        cnt_n   = len;
                        state_n = ACCUM;
                    end else begin
                        acc_out_n   = '0;
                        acc_valid_n = 1'b1;
                        state_n     = HOLD;
                    end
                end
            end

            ACCUM: begin
                if (prod_done) begin
                    acc_n = sum;
                    cnt_n = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        acc_out_n   = sum;
                        acc_valid_n = 1'b1;
                        state_n     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (prod_done) begin
                    err_n = 1'b1;
                end
                // A start in the accepting cycle chains straight into the next sum
                if (acc_ready) begin
                    acc_valid_n = 1'b0;
                    state_n     = IDLE;
                    if (start) begin
                        if (len != '0) begin
                            acc_n   = '0;
                            cnt_n   = len;
                            state_n = ACCUM;
                        end else begin
                            acc_out_n   = '0;
                            acc_valid_n = 1'b1;
                            state_n     = HOLD;
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
